display_scan: RTL

DISPLAY_SCAN -- requirements
Module: display_scan

---
 rtl/display_scan.sv | 133 +++++++++++++
 1 files changed

// File: rtl/display_scan.sv
// Six-digit multiplexed clock display: slot prescaler, digit scan, per-frame snapshot, 7-seg encode.
// Optional field blinking is compiled in with `define DISPLAY_BLINK_EN.
module display_scan #(
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       res,
  input  logic [6:0] h,
  input  logic [6:0] m,
  input  logic [6:0] s,
  input  logic       alarm_on,
  input  logic       blink_h,
  input  logic       blink_m,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_tick
);

  localparam logic [15:0] PRESC_MAX = 16'(SCAN_DIV - 1);
  localparam logic [6:0]  SEG_DASH  = 7'b1000000;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b0111111;
      4'd1:    return 7'b0000110;
      4'd2:    return 7'b1011011;
      4'd3:    return 7'b1001111;
      4'd4:    return 7'b1100110;
      4'd5:    return 7'b1101101;
      4'd6:    return 7'b1111101;
      4'd7:    return 7'b0000111;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  logic [15:0] presc, presc_nx;
  logic [2:0]  idx, idx_nx;
  logic        prime, bnd, frame;
  logic [6:0]  snap_h, snap_m, snap_s;
  logic [6:0]  nh, nm, ns, fld;
  logic [3:0]  dig;
  logic        dash, hide;

  // Outputs are registered from the next-cycle scan position so an/seg/dp
  // all switch on the same edge. After reset, a lead-in slot 0 shows the
  // cleared snapshot; its boundary is treated as the first frame start.
  always_comb begin
    bnd      = (presc == PRESC_MAX);
    frame    = bnd && ((idx == 3'd5) || prime);
    presc_nx = bnd ? 16'd0 : presc + 16'd1;
    idx_nx   = idx;
    if (frame)    idx_nx = 3'd0;
    else if (bnd) idx_nx = idx + 3'd1;
    nh = frame ? h : snap_h;
    nm = frame ? m : snap_m;
    ns = frame ? s : snap_s;
    case (idx_nx)
      3'd0, 3'd1: fld = ns;
      3'd2, 3'd3: fld = nm;
      default:    fld = nh;
    endcase
    dash = (fld > 7'd99);
    dig  = idx_nx[0] ? 4'(fld / 7'd10) : 4'(fld % 7'd10);
  end

`ifdef DISPLAY_BLINK_EN
  logic [7:0] fcnt, fcnt_nx;
  logic       phase, phase_nx;

  // phase=1 is the hidden half; the lead-in frame start is not counted.
  always_comb begin
    fcnt_nx  = fcnt;
    phase_nx = phase;
    if (frame && !prime) begin
      if (fcnt == 8'(BLINK_FRAMES - 1)) begin
        fcnt_nx  = 8'd0;
        phase_nx = ~phase;
      end else begin
        fcnt_nx = fcnt + 8'd1;
      end
    end
    hide = phase_nx && ((blink_h && (idx_nx >= 3'd4)) ||
                        (blink_m && ((idx_nx == 3'd2) || (idx_nx == 3'd3))));
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      fcnt  <= 8'd0;
      phase <= 1'b0;
    end else begin
      fcnt  <= fcnt_nx;
      phase <= phase_nx;
    end
  end
`else
  logic unused_blink;
  assign unused_blink = blink_h ^ blink_m ^ (BLINK_FRAMES != 0);
  assign hide = 1'b0;
`endif

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      presc      <= 16'd0;
      idx        <= 3'd0;
      prime      <= 1'b1;
      snap_h     <= 7'd0;
      snap_m     <= 7'd0;
      snap_s     <= 7'd0;
      an         <= 6'b111111;
      seg        <= 7'd0;
      dp         <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      presc <= presc_nx;
      idx   <= idx_nx;
      if (frame) begin
        prime  <= 1'b0;
        snap_h <= h;
        snap_m <= m;
        snap_s <= s;
      end
      an         <= ((presc_nx == 16'd0) || hide) ? 6'b111111 : ~(6'b000001 << idx_nx);
      seg        <= dash ? SEG_DASH : seg7(dig);
      dp         <= (idx_nx == 3'd2) || (idx_nx == 3'd4) || ((idx_nx == 3'd0) && alarm_on);
      frame_tick <= frame;
    end
  end

endmodule
